// File: rtl/pwrseq_pkg.sv
// pwrseq_pkg: shared state encodings and parameter helpers for the power/reset/boot sequencer.
// Optional heartbeat feature is enabled in pwrseq_ctrl by defining PWRSEQ_HEARTBEAT_EN.
package pwrseq_pkg;

    localparam int unsigned STATE_W = 3;

    // Externally visible state encodings (driven on state_o)
    localparam logic [STATE_W-1:0] ST_OFF      = 3'd0;
    localparam logic [STATE_W-1:0] ST_RAMP_UP  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RST_HOLD = 3'd2;
    localparam logic [STATE_W-1:0] ST_CSB_HOLD = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN      = 3'd4;
    localparam logic [STATE_W-1:0] ST_RAMP_DN  = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        StOff     = ST_OFF,
        StRampUp  = ST_RAMP_UP,
        StRstHold = ST_RST_HOLD,
        StCsbHold = ST_CSB_HOLD,
        StRun     = ST_RUN,
        StRampDn  = ST_RAMP_DN
    } state_e;

    // A cycle parameter is usable if it is non-zero and fits a cnt_w-bit counter.
    function automatic logic cycles_fit(longint unsigned val, int unsigned cnt_w);
        longint unsigned max_val;
        max_val = (64'd1 << cnt_w) - 64'd1;
        return (val >= 64'd1) && (val <= max_val);
    endfunction

endpackage

// File: rtl/pwrseq_timer.sv
// pwrseq_timer: loadable down-counter. done pulses on the enabled cycle the count
// leaves 1, so a load of L raises done on the L-th enabled edge after the load.
// The count saturates at zero and never wraps.
module pwrseq_timer
    import pwrseq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority over counting; stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pwrseq_ctrl.sv
// pwrseq_ctrl: rail / core-reset / flash-CSB bring-up and reverse power-down sequencer
// with a bring-up watchdog. Define PWRSEQ_HEARTBEAT_EN to enable the RUN-state heartbeat
// pulse on hb_o; otherwise hb_o is tied low and the heartbeat counter is not built.
module pwrseq_ctrl
    import pwrseq_pkg::*;
#(
    parameter int unsigned N_RAILS         = 4,
    parameter int unsigned STEP_CYCLES     = 4,
    parameter int unsigned RST_HOLD_CYCLES = 80,
    parameter int unsigned CSB_HOLD_CYCLES = 6800,
    parameter int unsigned WDOG_CYCLES     = 8192,
    parameter int unsigned HB_CYCLES       = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               en_i,
    output logic [N_RAILS-1:0] rail_en_o,
    output logic               rst_n_o,
    output logic               csb_force_o,
    output logic               ready_o,
    output logic [STATE_W-1:0] state_o,
    output logic               wdog_expire_o,
    output logic               hb_o
);

    // Elaboration-time parameter bounds
    if ((N_RAILS < 1) || (N_RAILS > 8)) begin : g_bad_n_rails
        $error("pwrseq_ctrl: N_RAILS must be 1..8");
    end
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("pwrseq_ctrl: CNT_W must be 1..32");
    end
    if (!cycles_fit(STEP_CYCLES, CNT_W)) begin : g_bad_step
        $error("pwrseq_ctrl: STEP_CYCLES out of range for CNT_W");
    end
    if (!cycles_fit(RST_HOLD_CYCLES, CNT_W)) begin : g_bad_rst_hold
        $error("pwrseq_ctrl: RST_HOLD_CYCLES out of range for CNT_W");
    end
    if (!cycles_fit(CSB_HOLD_CYCLES, CNT_W)) begin : g_bad_csb_hold
        $error("pwrseq_ctrl: CSB_HOLD_CYCLES out of range for CNT_W");
    end
    if (!cycles_fit(WDOG_CYCLES, CNT_W)) begin : g_bad_wdog
        $error("pwrseq_ctrl: WDOG_CYCLES out of range for CNT_W");
    end
    if (!cycles_fit(HB_CYCLES, CNT_W)) begin : g_bad_hb
        $error("pwrseq_ctrl: HB_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0]   STEP_LD  = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0]   RST_LD   = CNT_W'(RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   CSB_LD   = CNT_W'(CSB_HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   WDOG_LD  = CNT_W'(WDOG_CYCLES);
    localparam logic [N_RAILS-1:0] RAIL_ONE = N_RAILS'(1);

    state_e             state_q, state_d;
    logic [N_RAILS-1:0] rail_q, rail_d;
    logic               rst_n_q, rst_n_d;
    logic               csb_q, csb_d;
    logic               ready_q, ready_d;
    logic               wdog_q, wdog_d;
    logic               hb_q, hb_d;

    logic               ph_load, ph_en, ph_done;
    logic [CNT_W-1:0]   ph_val;
    logic               wd_load, wd_en, wd_done;
    logic               go_down;

    // Phase timer: rail step spacing, reset hold and CSB hold
    pwrseq_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (ph_en),
        .done     (ph_done)
    );

    // Bring-up watchdog: loaded when leaving OFF, counts only until RUN is reached
    pwrseq_timer #(
        .CNT_W (CNT_W)
    ) u_wdog_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (wd_load),
        .load_val (WDOG_LD),
        .en       (wd_en),
        .done     (wd_done)
    );

    // State and output registers; synchronous reset drops every rail at once
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StOff;
            rail_q  <= '0;
            rst_n_q <= 1'b0;
            csb_q   <= 1'b1;
            ready_q <= 1'b0;
            wdog_q  <= 1'b0;
            hb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rail_q  <= rail_d;
            rst_n_q <= rst_n_d;
            csb_q   <= csb_d;
            ready_q <= ready_d;
            wdog_q  <= wdog_d;
            hb_q    <= hb_d;
        end
    end

    // Next-state, timer control and next output values
    always_comb begin
        state_d = state_q;
        rail_d  = rail_q;
        rst_n_d = rst_n_q;
        csb_d   = csb_q;
        ready_d = ready_q;
        wdog_d  = wdog_q;
        ph_load = 1'b0;
        ph_val  = STEP_LD;
        ph_en   = 1'b0;
        wd_load = 1'b0;
        wd_en   = 1'b0;
        go_down = 1'b0;

        case (state_q)
            StOff: begin
                // A sticky watchdog expiry locks the sequencer off until reset
                if (en_i && !wdog_q) begin
                    state_d = StRampUp;
                    ph_load = 1'b1;
                    wd_load = 1'b1;
                end
            end

            StRampUp, StRstHold, StCsbHold: begin
                ph_en = 1'b1;
                wd_en = 1'b1;
                // Watchdog beats an en_i drop, which beats any phase completion
                if (wd_done) begin
                    wdog_d  = 1'b1;
                    go_down = 1'b1;
                end else if (!en_i) begin
                    go_down = 1'b1;
                end else if (ph_done) begin
                    ph_load = 1'b1;
                    if (state_q == StRampUp) begin
                        // Rails are thermometer coded from bit 0 upward
                        rail_d = (rail_q << 1) | RAIL_ONE;
                        if (rail_d == '1) begin
                            state_d = StRstHold;
                            ph_val  = RST_LD;
                        end
                    end else if (state_q == StRstHold) begin
                        rst_n_d = 1'b1;
                        state_d = StCsbHold;
                        ph_val  = CSB_LD;
                    end else begin
                        csb_d   = 1'b0;
                        ready_d = 1'b1;
                        state_d = StRun;
                    end
                end
            end

            StRun: begin
                if (!en_i) begin
                    go_down = 1'b1;
                end
            end

            StRampDn: begin
                ph_en = 1'b1;
                // en_i is deliberately not looked at until OFF is reached
                if (rail_q == '0) begin
                    state_d = StOff;
                end else if (ph_done) begin
                    // Shifting down clears the highest set rail of the thermometer code
                    rail_d  = rail_q >> 1;
                    ph_load = 1'b1;
                    if (rail_d == '0) begin
                        state_d = StOff;
                    end
                end
            end

            default: begin
                state_d = StOff;
            end
        endcase

        // Power-down entry: reset and CSB are asserted on the trigger edge itself
        if (go_down) begin
            state_d = StRampDn;
            rst_n_d = 1'b0;
            csb_d   = 1'b1;
            ready_d = 1'b0;
            ph_load = 1'b1;
            ph_val  = STEP_LD;
        end
    end

`ifdef PWRSEQ_HEARTBEAT_EN
    localparam logic [CNT_W-1:0] HB_LD = CNT_W'(HB_CYCLES);

    logic             hb_load, hb_done;
    logic [CNT_W-1:0] hb_val;

    // Heartbeat reload on RUN entry and on every period; cleared when leaving RUN
    always_comb begin
        hb_load = 1'b0;
        hb_val  = '0;
        hb_d    = 1'b0;
        if (state_d == StRun) begin
            if ((state_q != StRun) || hb_done) begin
                hb_load = 1'b1;
                hb_val  = HB_LD;
            end
            hb_d = hb_done;
        end else if (state_q == StRun) begin
            hb_load = 1'b1;
        end
    end

    pwrseq_timer #(
        .CNT_W (CNT_W)
    ) u_hb_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (hb_load),
        .load_val (hb_val),
        .en       (state_q == StRun),
        .done     (hb_done)
    );
`else
    assign hb_d = 1'b0;
`endif

    assign rail_en_o     = rail_q;
    assign rst_n_o       = rst_n_q;
    assign csb_force_o   = csb_q;
    assign ready_o       = ready_q;
    assign state_o       = state_q;
    assign wdog_expire_o = wdog_q;
    assign hb_o          = hb_q;

endmodule

// File: tb/tb_pwrseq_ctrl.sv
// tb_pwrseq_ctrl: table-driven scoreboard bench for pwrseq_ctrl. Two instances share clock
// and reset: dut_a with default timing, dut_b with WDOG_CYCLES=1000 to force a watchdog trip.
module tb_pwrseq_ctrl;

`ifdef PWRSEQ_HEARTBEAT_EN
  localparam logic HbEn = 1'b1;
`else
  localparam logic HbEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;

  logic [3:0] a_rail, b_rail;
  logic       a_rst_n, b_rst_n, a_csb, b_csb, a_ready, b_ready;
  logic [2:0] a_st, b_st;
  logic       a_wdog, b_wdog, a_hb, b_hb;

  always #5 clk = ~clk;

  pwrseq_ctrl dut_a (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .en_i          (en_a),
    .rail_en_o     (a_rail),
    .rst_n_o       (a_rst_n),
    .csb_force_o   (a_csb),
    .ready_o       (a_ready),
    .state_o       (a_st),
    .wdog_expire_o (a_wdog),
    .hb_o          (a_hb)
  );

  pwrseq_ctrl #(
    .WDOG_CYCLES (1000)
  ) dut_b (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .en_i          (en_b),
    .rail_en_o     (b_rail),
    .rst_n_o       (b_rst_n),
    .csb_force_o   (b_csb),
    .ready_o       (b_ready),
    .state_o       (b_st),
    .wdog_expire_o (b_wdog),
    .hb_o          (b_hb)
  );

  typedef struct {
    int         grp;
    int         dut;
    int         at;
    logic [3:0] rail;
    logic       rst_n;
    logic       csb;
    logic       ready;
    logic [2:0] st;
    logic       wdog;
    logic       hb;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int grp, int dut, int off, logic [3:0] rail, logic rst_n,
                              logic csb, logic ready, logic [2:0] st, logic wdog, logic hb);
    vec_t v;
    v.grp = grp; v.dut = dut; v.at = off; v.rail = rail; v.rst_n = rst_n;
    v.csb = csb; v.ready = ready; v.st = st; v.wdog = wdog; v.hb = hb;
    tbl.push_back(v);
  endfunction

  // Push every vector of a group into the scoreboard, ordered by absolute edge
  function automatic void apply_group(int grp, int base);
    foreach (tbl[i]) begin
      if (tbl[i].grp == grp) begin
        vec_t v;
        int   idx;
        v    = tbl[i];
        v.at = base + tbl[i].at;
        v.hb = tbl[i].hb & HbEn;
        idx  = sbq.size();
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].at > v.at) begin
            idx = j;
            break;
          end
        end
        sbq.insert(idx, v);
      end
    end
  endfunction

  function automatic logic [11:0] pack(logic [3:0] rail, logic rst_n, logic csb, logic ready,
                                       logic [2:0] st, logic wdog, logic hb);
    return {rail, rst_n, csb, ready, st, wdog, hb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  // Scoreboard checker: after each edge, compare every entry due at that edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while ((sbq.size() > 0) && (sbq[0].at <= cyc)) begin
        vec_t        v;
        logic [11:0] act, exp;
        v   = sbq.pop_front();
        exp = pack(v.rail, v.rst_n, v.csb, v.ready, v.st, v.wdog, v.hb);
        if (v.dut == 0) act = pack(a_rail, a_rst_n, a_csb, a_ready, a_st, a_wdog, a_hb);
        else            act = pack(b_rail, b_rst_n, b_csb, b_ready, b_st, b_wdog, b_hb);
        checks++;
        if ((v.at != cyc) || (act !== exp)) begin
          errors++;
          $display("FAIL grp%0d dut%0d edge %0d (due %0d): got %b want %b",
                   v.grp, v.dut, cyc, v.at, act, exp);
        end
      end
    end
  end

  int e, d, e2, e3, e4, p;

  initial begin
    // fields: grp dut off rail rst_n csb ready state wdog hb
    // 0: reset values on both DUTs (en_a held high during reset)
    for (int i = 0; i < 4; i++) begin
      add(0, 0, i, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
      add(0, 1, i, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    end
    // 1: full bring-up on dut_a, then heartbeat in RUN
    add(1, 0,    0, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,    3, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,    4, 4'b0001, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,    8, 4'b0011, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,   12, 4'b0111, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,   15, 4'b0111, 0, 1, 0, 3'd1, 0, 0);
    add(1, 0,   16, 4'b1111, 0, 1, 0, 3'd2, 0, 0);
    add(1, 0,   95, 4'b1111, 0, 1, 0, 3'd2, 0, 0);
    add(1, 0,   96, 4'b1111, 1, 1, 0, 3'd3, 0, 0);
    add(1, 0, 6895, 4'b1111, 1, 1, 0, 3'd3, 0, 0);
    add(1, 0, 6896, 4'b1111, 1, 0, 1, 3'd4, 0, 0);
    add(1, 0, 7895, 4'b1111, 1, 0, 1, 3'd4, 0, 0);
    add(1, 0, 7896, 4'b1111, 1, 0, 1, 3'd4, 0, 1);
    add(1, 0, 7897, 4'b1111, 1, 0, 1, 3'd4, 0, 0);
    add(1, 0, 8896, 4'b1111, 1, 0, 1, 3'd4, 0, 1);
    add(1, 0, 8897, 4'b1111, 1, 0, 1, 3'd4, 0, 0);
    // 2: power-down from RUN; en_a re-raised mid ramp-down is ignored
    add(2, 0,  0, 4'b1111, 0, 1, 0, 3'd5, 0, 0);
    add(2, 0,  3, 4'b1111, 0, 1, 0, 3'd5, 0, 0);
    add(2, 0,  4, 4'b0111, 0, 1, 0, 3'd5, 0, 0);
    add(2, 0,  8, 4'b0011, 0, 1, 0, 3'd5, 0, 0);
    add(2, 0, 12, 4'b0001, 0, 1, 0, 3'd5, 0, 0);
    add(2, 0, 16, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    // 3: restart from OFF, then en drop on the same edge a rail would rise
    add(3, 0,  0, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(3, 0,  4, 4'b0001, 0, 1, 0, 3'd1, 0, 0);
    add(3, 0,  8, 4'b0011, 0, 1, 0, 3'd1, 0, 0);
    add(3, 0, 11, 4'b0011, 0, 1, 0, 3'd1, 0, 0);
    add(3, 0, 12, 4'b0011, 0, 1, 0, 3'd5, 0, 0);
    add(3, 0, 16, 4'b0001, 0, 1, 0, 3'd5, 0, 0);
    add(3, 0, 19, 4'b0001, 0, 1, 0, 3'd5, 0, 0);
    add(3, 0, 20, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    add(3, 0, 21, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    // 4: abort before any rail rose
    add(4, 0, 0, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(4, 0, 1, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(4, 0, 2, 4'b0000, 0, 1, 0, 3'd5, 0, 0);
    add(4, 0, 3, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    add(4, 0, 6, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    // 5: dut_b watchdog trip in CSB_HOLD
    add(5, 1,    0, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(5, 1,   16, 4'b1111, 0, 1, 0, 3'd2, 0, 0);
    add(5, 1,   96, 4'b1111, 1, 1, 0, 3'd3, 0, 0);
    add(5, 1,  999, 4'b1111, 1, 1, 0, 3'd3, 0, 0);
    add(5, 1, 1000, 4'b1111, 0, 1, 0, 3'd5, 1, 0);
    add(5, 1, 1004, 4'b0111, 0, 1, 0, 3'd5, 1, 0);
    add(5, 1, 1015, 4'b0001, 0, 1, 0, 3'd5, 1, 0);
    add(5, 1, 1016, 4'b0000, 0, 1, 0, 3'd0, 1, 0);
    add(5, 1, 1100, 4'b0000, 0, 1, 0, 3'd0, 1, 0);
    // 6: dut_b still locked off later, en_b still high
    add(6, 1, 0, 4'b0000, 0, 1, 0, 3'd0, 1, 0);
    // 7: second bring-up on dut_a
    add(7, 0,   16, 4'b1111, 0, 1, 0, 3'd2, 0, 0);
    add(7, 0, 6896, 4'b1111, 1, 0, 1, 3'd4, 0, 0);
    // 8: reset pulse in RUN, then restart on both
    add(8, 0, 0, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    add(8, 1, 0, 4'b0000, 0, 1, 0, 3'd0, 0, 0);
    add(8, 0, 1, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(8, 1, 1, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(8, 0, 4, 4'b0000, 0, 1, 0, 3'd1, 0, 0);
    add(8, 0, 5, 4'b0001, 0, 1, 0, 3'd1, 0, 0);
    add(8, 1, 5, 4'b0001, 0, 1, 0, 3'd1, 0, 0);

    rst  = 1'b1;
    en_a = 1'b1;
    en_b = 1'b0;
    step();
    apply_group(0, cyc + 1);
    wait_until(4);
    rst  = 1'b0;
    en_a = 1'b0;

    wait_until(6);
    en_a = 1'b1;
    en_b = 1'b1;
    e = cyc + 1;
    apply_group(1, e);
    apply_group(5, e);

    d = e + 8906;
    wait_until(d - 1);
    en_a = 1'b0;
    apply_group(2, d);
    wait_until(d + 5);
    en_a = 1'b1;
    e2 = d + 17;
    apply_group(3, e2);
    wait_until(e2 + 11);
    en_a = 1'b0;

    wait_until(e2 + 22);
    en_a = 1'b1;
    e3 = cyc + 1;
    apply_group(4, e3);
    wait_until(e3 + 1);
    en_a = 1'b0;

    wait_until(e3 + 10);
    apply_group(6, cyc + 1);
    en_a = 1'b1;
    e4 = cyc + 1;
    apply_group(7, e4);

    wait_until(e4 + 6901);
    rst = 1'b1;
    p = cyc + 1;
    apply_group(8, p);
    step();
    rst = 1'b0;

    for (int k = 0; (k < 20) && (sbq.size() > 0); k++) step();
    while (sbq.size() > 0) begin
      vec_t v;
      v = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL grp%0d dut%0d due %0d: never compared, reached edge %0d",
               v.grp, v.dut, v.at, cyc);
    end

    // Direct post-restart checks: both DUTs ramping up, reset still held, watchdog cleared
    checks++;
    if (a_st !== 3'd1) begin
      errors++;
      $display("FAIL direct: dut_a state %0d, want 1", a_st);
    end
    checks++;
    if (b_st !== 3'd1) begin
      errors++;
      $display("FAIL direct: dut_b state %0d, want 1", b_st);
    end
    checks++;
    if (b_wdog !== 1'b0) begin
      errors++;
      $display("FAIL direct: dut_b wdog_expire_o %b, want 0", b_wdog);
    end
    checks++;
    if ((a_rst_n !== 1'b0) || (a_csb !== 1'b1)) begin
      errors++;
      $display("FAIL direct: dut_a rst_n %b csb %b, want 0 1", a_rst_n, a_csb);
    end
    checks++;
    if (a_rail !== b_rail) begin
      errors++;
      $display("FAIL direct: rails differ after restart: %b vs %b", a_rail, b_rail);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwrseq_ctrl.md
Name: pwrseq_ctrl

Overview:
- Parametrised power/reset/boot sequencer for the jacaranda-8 user project; generalises the fixed rail, reset and flash-CSB bring-up timing into synthesizable RTL.
- Brings up N enable rails in order, then holds and releases core reset, then releases the forced flash chip-select.
- Sequences down in reverse on request.
- Provides a bring-up watchdog and an optional run-time heartbeat.

Parameters:
N_RAILS, 4, number of sequenced enable rails (1..8)
STEP_CYCLES, 4, cycles between successive rail edges (>=1)
RST_HOLD_CYCLES, 80, cycles from last rail up to reset release (>=1)
CSB_HOLD_CYCLES, 6800, cycles from reset release to CSB release (>=1)
WDOG_CYCLES, 8192, max cycles from leaving OFF to reaching RUN
HB_CYCLES, 1000, heartbeat period in RUN
CNT_W, 16, counter width; must hold every cycle parameter

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
en_i  in  1  power request: high = bring up, low = bring down
rail_en_o  out  N_RAILS  rail enables, bit 0 first up, last down
rst_n_o  out  1  core reset, active-low
csb_force_o  out  1  1 = force flash CSB high
ready_o  out  1  sequence complete (state RUN)
state_o  out  3  current state encoding
wdog_expire_o  out  1  sticky bring-up timeout flag
hb_o  out  1  one-cycle heartbeat pulse

Behaviour:
- Reset state (every edge with wb_rst_i=1), all outputs: rail_en_o=0, rst_n_o=0, csb_force_o=1, ready_o=0, wdog_expire_o=0, hb_o=0, state OFF. Reset dominates all other inputs.
- Reset mid-operation drops all rails at once; there is no sequenced power-down.
- State encodings: OFF=0, RAMP_UP=1, RST_HOLD=2, CSB_HOLD=3, RUN=4, RAMP_DN=5.
- OFF: en_i sampled high at edge E -> RAMP_UP. The watchdog counter starts at E.
- RAMP_UP: rail k rises at edge E+STEP_CYCLES*(k+1). On the edge the last rail rises -> RST_HOLD.
- RST_HOLD: after RST_HOLD_CYCLES, rst_n_o=1 -> CSB_HOLD.
- CSB_HOLD: after CSB_HOLD_CYCLES, csb_force_o=0, ready_o=1 -> RUN. The watchdog stops.
- RUN: holds until en_i=0.
- Power-down trigger: en_i sampled low in RAMP_UP, RST_HOLD, CSB_HOLD or RUN at edge D.
  - Same edge: rst_n_o=0, csb_force_o=1, ready_o=0 -> RAMP_DN.
  - The step timer restarts at D.
- RAMP_DN: clears the highest set rail every STEP_CYCLES. On the edge rail_en_o becomes 0 -> OFF. en_i is ignored until OFF is reached; OFF re-evaluates en_i on the next edge.
- RAMP_DN with no rails set (abort before the first rail rose) -> OFF on the next edge.
- Watchdog: if RUN has not been entered by edge E+WDOG_CYCLES, then at that edge:
  - wdog_expire_o=1 (sticky until wb_rst_i).
  - Forced RAMP_DN, identical to an en_i drop.
  - While wdog_expire_o=1, OFF does not leave on en_i.
- Simultaneous events:
  - en_i drop beats timer completion.
  - Watchdog expiry on the same edge as CSB_HOLD completion: watchdog wins, RUN is not entered.
- Counters are CNT_W bits, reload on every state entry, and never wrap inside a phase. Parameter bounds are checked at elaboration (error if a parameter is 0 or exceeds 2**CNT_W-1).

Optional Feature:
- PWRSEQ_HEARTBEAT_EN defined:
  - hb_o pulses for 1 cycle at RUN entry + k*HB_CYCLES (k>=1).
  - The counter clears on leaving RUN.
- Undefined: hb_o tied 0, heartbeat counter absent.

Decomposition:
- Package pwrseq_pkg: state encodings (3-bit localparams), STATE_W=3.
- Sub-module pwrseq_timer: loadable CNT_W down-counter with load/enable and a one-cycle done output.
  - Instanced for the phase timer, the watchdog, and the heartbeat (when enabled).

Test Plan:
- Defaults, en_i high at E -> rail_en_o 0001/0011/0111/1111 at E+4/8/12/16; rst_n_o rises at E+96; csb_force_o falls and ready_o rises at E+6896; state_o=4.
- From RUN, en_i low at D -> rst_n_o=0, csb_force_o=1, ready_o=0 at D; rails 0111/0011/0001/0000 at D+4/8/12/16; state_o=0 at D+16.
- Abort with rails 0011 at edge D -> rail_en_o 0001 at D+4, 0000 and OFF at D+8; rst_n_o never rises.
- WDOG_CYCLES=1000 -> wdog_expire_o=1 at E+1000 in CSB_HOLD; ramp-down completes E+1016; en_i held high keeps OFF until wb_rst_i.
- wb_rst_i pulsed in RUN -> next edge all outputs at reset values, rail_en_o=0 at once; a new en_i restarts the full sequence.
- With PWRSEQ_HEARTBEAT_EN: hb_o pulses at RUN entry+1000 and +2000, exactly 1 cycle each; without the macro, hb_o stays 0.
